// File: rtl/or18_pkg.sv
`default_nettype none
// ============================================================================
// Module      : or18_pkg
// Description : Shared definitions for the 18-bit OR unit operand loader.
//               Holds the default operand/beat widths, the loader state
//               encoding and a helper that sizes the beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
package or18_pkg;

    // Default operand width of the OR stage and the input beat width.
    localparam int OR_DATA_W = 18;
    localparam int OR_BEAT_W = 6;

    // Loader states: collect operand A, collect operand B, hold the pair.
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // Width of a counter that indexes BEATS beats. Never returns zero, so a
    // single-beat operand still gets a legal 1-bit counter.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage : or18_pkg
`default_nettype wire

// File: rtl/or18_operand_loader_deser.sv
`default_nettype none
// ============================================================================
// Module      : or18_operand_loader_deser
// Description : Beat deserializer for one operand. Each enabled beat is
//               stored in the slot selected by the shared beat counter.
//               word_o is the staged operand with the incoming beat already
//               merged in while load_i is high, so the owner can capture a
//               complete operand on the same edge as its final beat.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               clear_i      - synchronous discard of all staged beats
//               load_i       - a beat for this operand transfers this cycle
//               cnt_i        - slot index of the beat (LS beat first)
//               beat_i       - beat data
//               word_o       - staged operand (with bypass of beat_i)
//               last_beat_o  - cnt_i addresses the most-significant slot
// Revision    : 1.0 - initial release
// ============================================================================
module or18_operand_loader_deser
    import or18_pkg::*;
#(
    parameter int DATA_W = OR_DATA_W,
    parameter int BEAT_W = OR_BEAT_W,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic [DATA_W-1:0] word_o,
    output logic              last_beat_o
);

    localparam int BEATS = DATA_W / BEAT_W;

    logic [BEAT_W-1:0] beat_q [BEATS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BEATS; i++) begin
                beat_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < BEATS; i++) begin
                beat_q[i] <= '0;
            end
        end else if (load_i) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt_i == CNT_W'(i)) begin
                    beat_q[i] <= beat_i;
                end
            end
        end
    end

    // Merge the in-flight beat into its slot so the final beat does not
    // need an extra cycle to land before the operand is captured.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
        assign word_o[gi*BEAT_W +: BEAT_W] =
            (load_i && (cnt_i == CNT_W'(gi))) ? beat_i : beat_q[gi];
    end

    assign last_beat_o = (cnt_i == CNT_W'(BEATS - 1));

endmodule : or18_operand_loader_deser
`default_nettype wire

// File: rtl/or18_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : or18_operand_loader
// Description : Upstream stage of the 18-bit OR unit. Assembles operand A and
//               then operand B from LS-first beats (valid/ready), presents
//               the pair as registered outputs (valid/ready) and reopens the
//               input only after the pair has been consumed.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               clear               - synchronous abort of load and held pair
//               in_data/valid/ready - beat input handshake
//               a, b                - operand pair to the OR stage
//               out_valid/out_ready - pair output handshake
//               busy                - a pair is partially loaded or held
// Revision    : 1.0 - initial release
// ============================================================================
module or18_operand_loader
    import or18_pkg::*;
#(
    parameter int DATA_W = OR_DATA_W,
    parameter int BEAT_W = OR_BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int BEATS = DATA_W / BEAT_W;
    localparam int CNT_W = cnt_width(BEATS);

    // Operands must split into whole beats.
    if ((BEAT_W < 1) || (DATA_W % BEAT_W != 0)) begin : g_bad_width
        $fatal(1, "or18_operand_loader: DATA_W must be a multiple of BEAT_W");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic               out_valid_q, out_valid_d;

    logic               w_xfer;
    logic               w_load_a;
    logic               w_load_b;
    logic               w_last_a;
    logic               w_last_b;
    logic               w_last;
    logic [DATA_W-1:0]  w_word_a;
    logic [DATA_W-1:0]  w_word_b;

    assign in_ready = (state_q != HOLD);
    assign w_xfer   = in_valid & in_ready;

    // A beat presented together with clear is dropped, so clear gates the
    // staging writes as well as the state update.
    assign w_load_a = w_xfer & ~clear & (state_q == LOAD_A);
    assign w_load_b = w_xfer & ~clear & (state_q == LOAD_B);

    or18_operand_loader_deser #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_deser_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .load_i      (w_load_a),
        .cnt_i       (cnt_q),
        .beat_i      (in_data),
        .word_o      (w_word_a),
        .last_beat_o (w_last_a)
    );

    or18_operand_loader_deser #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_deser_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .load_i      (w_load_b),
        .cnt_i       (cnt_q),
        .beat_i      (in_data),
        .word_o      (w_word_b),
        .last_beat_o (w_last_b)
    );

    assign w_last = (state_q == LOAD_A) ? w_last_a : w_last_b;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            LOAD_A: begin
                if (w_xfer) begin
                    if (w_last) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (w_xfer) begin
                    if (w_last) begin
                        // Operand A is complete in its staging register;
                        // operand B still needs the beat arriving now.
                        cnt_d       = '0;
                        a_d         = w_word_a;
                        b_d         = w_word_b;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = LOAD_A;
                end
            end
            default: begin
                cnt_d       = '0;
                out_valid_d = 1'b0;
                state_d     = LOAD_A;
            end
        endcase

        // Abort overrides every other event; the last delivered pair stays
        // visible on a/b.
        if (clear) begin
            state_d     = LOAD_A;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            a_d         = a_q;
            b_d         = b_q;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign out_valid = out_valid_q;
    assign busy      = (cnt_q != '0) | (state_q != LOAD_A);

endmodule : or18_operand_loader
`default_nettype wire

// File: tb/tb_or18_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_or18_operand_loader
// Description : Self-checking bench for or18_operand_loader. A reference
//               model keeps the accepted beats of the current pair in a
//               queue and builds the expected operands arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or18_operand_loader;

    localparam int DW = 18;
    localparam int BW = 6;
    localparam int NB = DW / BW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    always #5 clk = ~clk;

    or18_operand_loader #(
        .DATA_W (DW),
        .BEAT_W (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [BW-1:0] pend[$];
    bit            held;
    logic [DW-1:0] ea, eb;
    bit            acc;
    int            cyc;
    bit            prev_ov;
    int            rises[$];

    task automatic model_reset();
        pend.delete();
        held    = 0;
        ea      = '0;
        eb      = '0;
        prev_ov = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, held});
        chk("in_ready",  {31'd0, in_ready},  {31'd0, !held});
        chk("busy",      {31'd0, busy},      {31'd0, (pend.size() != 0) || held});
        chk("a",         32'(a),             32'(ea));
        chk("b",         32'(b),             32'(eb));
        chk("or_result", 32'(a | b),         32'(ea | eb));
    endtask

    // Effect of the coming rising edge on the model.
    task automatic model_edge();
        acc = 0;
        if (clear) begin
            pend.delete();
            held = 0;
        end else if (held) begin
            if (out_ready) held = 0;
        end else if (in_valid) begin
            acc = 1;
            pend.push_back(in_data);
            if (pend.size() == 2 * NB) begin
                ea = '0;
                eb = '0;
                for (int k = 0; k < NB; k++) begin
                    ea = ea | (DW'(pend[k])      << (BW * k));
                    eb = eb | (DW'(pend[NB + k]) << (BW * k));
                end
                held = 1;
                pend.delete();
            end
        end
    endtask

    // One clock: check at the falling edge, predict, then leave the caller
    // 1 time unit after the rising edge to drive the next inputs.
    task automatic step();
        @(negedge clk);
        if (out_valid && !prev_ov) rises.push_back(cyc);
        prev_ov = out_valid;
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_beat(input logic [BW-1:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        acc      = 0;
        do begin
            step();
            guard++;
        end while (!acc && guard < 40);
        chk("accept_timeout", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    logic [BW-1:0] d;

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cyc       = 0;
        model_reset();

        // ---- reset values ----
        #2;
        chk("rst_a",         32'(a),                32'd0);
        chk("rst_b",         32'(b),                32'd0);
        chk("rst_out_valid", {31'd0, out_valid},    32'd0);
        chk("rst_busy",      {31'd0, busy},         32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ---- directed pair, consumer stalled ----
        send_beat(6'h01); send_beat(6'h02); send_beat(6'h03);
        send_beat(6'h3F); send_beat(6'h00); send_beat(6'h2A);
        chk("t1_valid",    {31'd0, out_valid}, 32'd1);
        chk("t1_a",        32'(a),             32'h03081);
        chk("t1_b",        32'(b),             32'h2A03F);
        chk("t1_in_ready", {31'd0, in_ready},  32'd0);
        in_valid = 1'b1;
        in_data  = 6'h15;
        step();
        step();
        in_valid = 1'b0;

        // ---- consume with a one-cycle out_ready pulse ----
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_valid",    {31'd0, out_valid}, 32'd0);
        chk("t2_in_ready", {31'd0, in_ready},  32'd1);
        chk("t2_a_kept",   32'(a),             32'h03081);
        chk("t2_b_kept",   32'(b),             32'h2A03F);
        step();

        // ---- back-to-back pairs ----
        rises.delete();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        d         = 6'h10;
        in_data   = d;
        for (int i = 0; i < 36; i++) begin
            step();
            if (acc) begin
                d       = d + 6'h01;
                in_data = d;
            end
        end
        in_valid = 1'b0;
        chk("b2b_pulses", {31'd0, rises.size() >= 4}, 32'd1);
        for (int i = 1; i < rises.size(); i++) begin
            chk("b2b_period", 32'(rises[i] - rises[i-1]), 32'd7);
        end
        step();
        step();
        out_ready = 1'b0;

        // ---- clear after 4 beats, then a fresh pair ----
        clear = 1'b1;
        step();
        clear = 1'b0;
        send_beat(6'h2B); send_beat(6'h1C); send_beat(6'h0D); send_beat(6'h3E);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'h27;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy",  {31'd0, busy},      32'd0);
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        step();
        send_beat(6'h11); send_beat(6'h22); send_beat(6'h33);
        send_beat(6'h04); send_beat(6'h05); send_beat(6'h06);
        chk("t4_a", 32'(a), 32'h33891);
        chk("t4_b", 32'(b), 32'h06144);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // ---- asynchronous reset while holding a pair ----
        send_beat(6'h3F); send_beat(6'h3F); send_beat(6'h3F);
        send_beat(6'h01); send_beat(6'h00); send_beat(6'h20);
        chk("t5_held", {31'd0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_a",     32'(a),             32'd0);
        chk("arst_b",     32'(b),             32'd0);
        chk("arst_busy",  {31'd0, busy},      32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_beat(6'h3F); send_beat(6'h3F); send_beat(6'h3F);
        send_beat(6'h01); send_beat(6'h00); send_beat(6'h20);
        chk("t5_a", 32'(a), 32'h3FFFF);
        chk("t5_b", 32'(b), 32'h20001);
        out_ready = 1'b1;
        step();

        // ---- randomized traffic against the model ----
        in_data = 6'($urandom);
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 59) == 0);
            step();
            if (acc) in_data = 6'($urandom);
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_or18_operand_loader
`default_nettype wire
